// File: rtl/ccc_clken_pkg.sv
// Shared types and parameter limits for the clock-enable generator.
package ccc_clken_pkg;

    // Lock sequencer states.
    typedef enum logic [1:0] {
        ST_WAIT,
        ST_STABLE,
        ST_RELEASE,
        ST_RUN
    } state_t;

    localparam int MIN_CH          = 1;
    localparam int MAX_CH          = 8;
    localparam int MIN_LOCK_STABLE = 1;
    localparam int MIN_STAGGER     = 1;
    localparam int MAX_COUNT       = 65535;

    // Keeps elaboration-time parameters inside their legal range.
    function automatic int clamp_int(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

endpackage

// File: rtl/ccc_clken_div.sv
// One clock-enable channel: programmable divider with a phase offset.
module ccc_clken_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] div_val,
    input  logic [DIV_W-1:0] phase_val,
    output logic             clk_en
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] phase_q;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] phase_eff;

    // Normalise the incoming ratio/offset: zero ratio means 1, offset clamps to ratio-1.
    always_comb begin
        div_eff   = (div_val == '0) ? DIV_W'(1) : div_val;
        phase_eff = (phase_val >= div_eff) ? (div_eff - DIV_W'(1)) : phase_val;
    end

    // Active ratio/offset registers, stored already normalised.
    // NOTE: these config registers get an explicit reset so a channel is usable (DIV=1) without any LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= DIV_W'(1);
            phase_q <= '0;
        end else if (load) begin
            div_q   <= div_eff;
            phase_q <= phase_eff;
        end
    end

    // Divider counter; the pulse is registered, one cycle after counter==phase.
    always_ff @(posedge clk) begin
        if (reset || load || !run) begin
            cnt    <= '0;
            clk_en <= 1'b0;
        end else begin
            clk_en <= (cnt == phase_q);
            cnt    <= (cnt == div_q - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/ccc_clken_gen.sv
// PLL-lock sequencer with staggered per-channel reset release and
// per-channel clock-enable dividers.
module ccc_clken_gen
    import ccc_clken_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int LOCK_STABLE = 16,
    parameter int STAGGER     = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    PLL_LOCK,
    input  logic                    LOAD,
    input  logic                    CLR_LOST,
    input  logic [NUM_CH*DIV_W-1:0] DIV_VAL,
    input  logic [NUM_CH*DIV_W-1:0] PHASE_VAL,
    input  logic [NUM_CH-1:0]       CH_EN,
    output logic [NUM_CH-1:0]       CLK_EN,
    output logic [NUM_CH-1:0]       CH_RST,
    output logic                    LOCKED,
    output logic                    LOCK_LOST
);

    localparam int LS_CYC  = clamp_int(LOCK_STABLE, MIN_LOCK_STABLE, MAX_COUNT);
    localparam int STG_CYC = clamp_int(STAGGER, MIN_STAGGER, MAX_COUNT);
    localparam int CH_LAST = clamp_int(NUM_CH, MIN_CH, MAX_CH) - 1;
    localparam int LS_W    = $clog2(LS_CYC + 1);
    localparam int STG_W   = $clog2(STG_CYC + 1);

    localparam logic [LS_W-1:0]   LS_END   = LS_W'(LS_CYC);
    localparam logic [STG_W-1:0]  STG_END  = STG_W'(STG_CYC);
    // Reset vector just before the last channel is released.
    localparam logic [NUM_CH-1:0] LAST_RST = NUM_CH'(1) << CH_LAST;

    logic              lock_m;
    logic              lock_s;
    state_t            state,    state_nxt;
    logic [LS_W-1:0]   stab_cnt, stab_cnt_nxt;
    logic [STG_W-1:0]  stg_cnt,  stg_cnt_nxt;
    logic [NUM_CH-1:0] ch_rst,   ch_rst_nxt;
    logic              lost,     lost_nxt;
    logic [NUM_CH-1:0] run;

    // Two-flop synchroniser for the asynchronous PLL lock.
    // NOTE: reset is synchronous, so it lives inside the clocked branch and is not in the sensitivity list.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= PLL_LOCK;
            lock_s <= lock_m;
        end
    end

    // Sequencer state, counters, channel resets and the sticky loss flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_WAIT;
            stab_cnt <= '0;
            stg_cnt  <= '0;
            ch_rst   <= '1;
            lost     <= 1'b0;
        end else begin
            state    <= state_nxt;
            stab_cnt <= stab_cnt_nxt;
            stg_cnt  <= stg_cnt_nxt;
            ch_rst   <= ch_rst_nxt;
            lost     <= lost_nxt;
        end
    end

    // Next-state logic: stability count, staggered release (one reset bit
    // cleared per step, lowest channel first), and loss handling.
    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        stab_cnt_nxt = stab_cnt;
        stg_cnt_nxt  = stg_cnt;
        ch_rst_nxt   = ch_rst;
        lost_nxt     = lost & ~CLR_LOST;

        case (state)
            ST_WAIT: begin
                if (lock_s) begin
                    state_nxt    = ST_STABLE;
                    stab_cnt_nxt = LS_W'(1);
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT;
                end else if (stab_cnt == LS_END) begin
                    state_nxt   = (ch_rst == LAST_RST) ? ST_RUN : ST_RELEASE;
                    ch_rst_nxt  = ch_rst << 1;
                    stg_cnt_nxt = STG_W'(1);
                end else begin
                    stab_cnt_nxt = stab_cnt + LS_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!lock_s) begin
                    state_nxt  = ST_WAIT;
                    ch_rst_nxt = '1;
                    lost_nxt   = 1'b1;
                end else if (stg_cnt == STG_END) begin
                    ch_rst_nxt  = ch_rst << 1;
                    stg_cnt_nxt = STG_W'(1);
                    if (ch_rst == LAST_RST) begin
                        state_nxt = ST_RUN;
                    end
                end else begin
                    stg_cnt_nxt = stg_cnt + STG_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt  = ST_WAIT;
                    ch_rst_nxt = '1;
                    lost_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt  = ST_WAIT;
                ch_rst_nxt = '1;
            end
        endcase
    end

    // A channel counts only while out of reset now and after this edge,
    // so a lock loss silences CLK_EN in the same cycle CH_RST reasserts.
    assign run = CH_EN & ~ch_rst & ~ch_rst_nxt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ccc_clken_div #(
            .DIV_W(DIV_W)
        ) u_div (
            .clk      (CLK),
            .reset    (RESET),
            .load     (LOAD),
            .run      (run[i]),
            .div_val  (DIV_VAL[i*DIV_W +: DIV_W]),
            .phase_val(PHASE_VAL[i*DIV_W +: DIV_W]),
            .clk_en   (CLK_EN[i])
        );
    end

    assign CH_RST    = ch_rst;
    assign LOCKED    = (state == ST_RUN);
    assign LOCK_LOST = lost;

endmodule

// File: tb/tb_ccc_clken_gen.sv
// Self-checking bench for ccc_clken_gen: directed sequences, a vector table
// for divide/phase normalisation, and randomized traffic against a
// run-length based reference model.
module tb_ccc_clken_gen;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 8;
    localparam int LS     = 16;
    localparam int STG    = 4;
    localparam int R_CAP  = 1000;

    logic                    clk;
    logic                    reset;
    logic                    pll_lock;
    logic                    load;
    logic                    clr_lost;
    logic [NUM_CH*DIV_W-1:0] div_val;
    logic [NUM_CH*DIV_W-1:0] phase_val;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       clk_en;
    logic [NUM_CH-1:0]       ch_rst;
    logic                    locked;
    logic                    lock_lost;

    ccc_clken_gen #(
        .NUM_CH     (NUM_CH),
        .DIV_W      (DIV_W),
        .LOCK_STABLE(LS),
        .STAGGER    (STG)
    ) dut (
        .CLK      (clk),
        .RESET    (reset),
        .PLL_LOCK (pll_lock),
        .LOAD     (load),
        .CLR_LOST (clr_lost),
        .DIV_VAL  (div_val),
        .PHASE_VAL(phase_val),
        .CH_EN    (ch_en),
        .CLK_EN   (clk_en),
        .CH_RST   (ch_rst),
        .LOCKED   (locked),
        .LOCK_LOST(lock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model. The sequencer is described by r, the number of
    // consecutive edges at which the synchronised lock was seen high:
    // channel i is out of reset once r >= LS+1+i*STG, LOCKED once the
    // last channel is out. Channels are described by m, the number of
    // consecutive edges they have been running: a pulse follows every edge
    // where m mod DIV equals PHASE.
    bit [1:0]          pipe;
    int                r;
    bit                m_lost;
    int                m_div [NUM_CH];
    int                m_ph  [NUM_CH];
    int                m_cnt [NUM_CH];
    bit [NUM_CH-1:0]   m_en;
    int                rel   [NUM_CH];

    typedef struct {
        int div;
        int phase;
        int period;
        int offset;
    } vec_t;
    vec_t vecs [8];

    function automatic int thr(input int i);
        return LS + 1 + i * STG;
    endfunction

    function automatic logic [9:0] exp_vec();
        logic [NUM_CH-1:0] rst;
        for (int i = 0; i < NUM_CH; i++) rst[i] = !(r >= thr(i));
        return {m_en, rst, (r >= thr(NUM_CH - 1)), m_lost};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_win(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Advances the model by the edge about to happen, using the inputs it will sample.
    task automatic model_edge();
        bit                ls;
        int                r_new;
        int                dv;
        int                pv;
        bit [NUM_CH-1:0]   rst_before;
        bit [NUM_CH-1:0]   rst_after;
        if (reset) begin
            pipe   = 2'b00;
            r      = 0;
            m_lost = 1'b0;
            m_en   = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i] = 1;
                m_ph[i]  = 0;
                m_cnt[i] = 0;
            end
            return;
        end
        ls    = pipe[1];
        pipe  = {pipe[0], pll_lock};
        r_new = ls ? ((r < R_CAP) ? r + 1 : r) : 0;
        for (int i = 0; i < NUM_CH; i++) begin
            rst_before[i] = !(r >= thr(i));
            rst_after[i]  = !(r_new >= thr(i));
        end
        if (!ls && r >= LS + 1) m_lost = 1'b1;
        else if (clr_lost)      m_lost = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load) begin
                dv       = int'(div_val[i*DIV_W +: DIV_W]);
                pv       = int'(phase_val[i*DIV_W +: DIV_W]);
                m_div[i] = (dv == 0) ? 1 : dv;
                m_ph[i]  = (pv >= m_div[i]) ? m_div[i] - 1 : pv;
                m_cnt[i] = 0;
                m_en[i]  = 1'b0;
            end else if (ch_en[i] && !rst_before[i] && !rst_after[i]) begin
                m_en[i]  = ((m_cnt[i] % m_div[i]) == m_ph[i]);
                m_cnt[i] = m_cnt[i] + 1;
            end else begin
                m_en[i]  = 1'b0;
                m_cnt[i] = 0;
            end
        end
        r = r_new;
    endtask

    // One clock: model update, edge, then compare outputs 1 time unit later.
    // NOTE: outputs are sampled #1 after the edge so they are settled and never race the flops.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check("outputs", int'({clk_en, ch_rst, locked, lock_lost}), int'(exp_vec()));
    endtask

    // Waits (bounded) for LOCKED, recording when each channel leaves reset.
    task automatic wait_lock(output int t_lock);
        t_lock = -1;
        for (int i = 0; i < NUM_CH; i++) rel[i] = -1;
        for (int t = 1; t <= 100; t++) begin
            tick();
            for (int i = 0; i < NUM_CH; i++)
                if (rel[i] < 0 && ch_rst[i] == 1'b0) rel[i] = t;
            if (locked) begin
                t_lock = t;
                break;
            end
        end
    endtask

    initial begin
        int t_lock;
        int first;
        int second;
        int cnt_a;
        int cnt_b;
        int low_left;

        vecs[0] = '{4, 2, 4, 3};
        vecs[1] = '{1, 0, 1, 1};
        vecs[2] = '{0, 0, 1, 1};
        vecs[3] = '{5, 9, 5, 5};
        vecs[4] = '{3, 3, 3, 3};
        vecs[5] = '{0, 7, 1, 1};
        vecs[6] = '{7, 6, 7, 7};
        vecs[7] = '{2, 1, 2, 2};

        reset     = 1'b1;
        pll_lock  = 1'b0;
        load      = 1'b0;
        clr_lost  = 1'b0;
        div_val   = '0;
        phase_val = '0;
        ch_en     = '1;

        // Reset state, then idle with no lock.
        repeat (3) tick();
        check("reset_outputs", int'({clk_en, ch_rst, locked, lock_lost}), int'(10'b0000_1111_0_0));
        reset = 1'b0;
        repeat (10) tick();
        check("idle_no_lock", int'({ch_rst, locked}), int'(5'b1111_0));

        // Lock-up sequence with default parameters.
        pll_lock = 1'b1;
        wait_lock(t_lock);
        check_win("lock_latency", t_lock, 30, 32);
        for (int i = 1; i < NUM_CH; i++)
            check($sformatf("release_spacing_%0d", i), rel[i] - rel[i-1], STG);
        check("run_with_last_release", t_lock, rel[NUM_CH-1]);

        // Divide/phase normalisation on channel 0, one LOAD per vector.
        for (int k = 0; k < 8; k++) begin
            div_val[DIV_W-1:0]   = DIV_W'(vecs[k].div);
            phase_val[DIV_W-1:0] = DIV_W'(vecs[k].phase);
            load = 1'b1;
            tick();
            load = 1'b0;
            first  = -1;
            second = -1;
            for (int j = 1; j <= 40 && second < 0; j++) begin
                tick();
                if (clk_en[0]) begin
                    if (first < 0) first = j;
                    else           second = j;
                end
            end
            check($sformatf("vec%0d_offset", k), first, vecs[k].offset);
            check($sformatf("vec%0d_period", k), second - first, vecs[k].period);
        end

        // Mixed configuration loaded while running.
        div_val   = {8'd5, 8'd0, 8'd1, 8'd4};
        phase_val = {8'd9, 8'd0, 8'd0, 8'd2};
        load = 1'b1;
        tick();
        load  = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        first = -1;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (clk_en[2:1] != 2'b11) cnt_a++;
            if (clk_en[0]) cnt_b++;
            if (clk_en[3] && first < 0) first = j;
        end
        check("ch1_ch2_always_on", cnt_a, 0);
        check("ch0_pulses_in_20", cnt_b, 5);
        check("ch3_first_pulse", first, 5);

        // Channel 1 disabled for 10 cycles.
        ch_en[1] = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (clk_en[1]) cnt_a++;
            if (clk_en[2]) cnt_b++;
        end
        check("ch1_disabled_silent", cnt_a, 0);
        check("ch2_unaffected", cnt_b, 10);
        ch_en[1] = 1'b1;
        tick();
        check("ch1_restart", int'(clk_en[1]), 1);
        repeat (10) tick();

        // Lock drops for 3 cycles while running.
        pll_lock = 1'b0;
        repeat (3) tick();
        check("loss_outputs", int'({clk_en, ch_rst, locked, lock_lost}), int'(10'b0000_1111_0_1));
        pll_lock = 1'b1;
        wait_lock(t_lock);
        check_win("relock_latency", t_lock, 30, 32);
        check("lost_sticky", int'(lock_lost), 1);
        clr_lost = 1'b1;
        tick();
        clr_lost = 1'b0;
        check("lost_cleared", int'(lock_lost), 0);
        repeat (5) tick();

        // Reset mid-run overrides LOAD and CLR_LOST.
        reset     = 1'b1;
        load      = 1'b1;
        clr_lost  = 1'b1;
        div_val   = {4{8'd3}};
        phase_val = '0;
        tick();
        check("reset_midrun", int'({clk_en, ch_rst, locked, lock_lost}), int'(10'b0000_1111_0_0));
        reset    = 1'b0;
        load     = 1'b0;
        clr_lost = 1'b0;

        // Lock glitch during the stability count.
        cnt_a = 0;
        for (int j = 1; j <= 9; j++) begin
            pll_lock = (j != 9);
            tick();
            if (lock_lost) cnt_a++;
        end
        pll_lock = 1'b1;
        wait_lock(t_lock);
        check_win("glitch_restart_latency", t_lock, 30, 32);
        check("glitch_no_lost", cnt_a + int'(lock_lost), 0);

        // Randomized traffic against the model.
        low_left = 0;
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 799) == 0);
            if (low_left > 0) begin
                pll_lock = 1'b0;
                low_left--;
            end else begin
                pll_lock = 1'b1;
                if ($urandom_range(0, 149) == 0) low_left = $urandom_range(1, 5);
            end
            load = ($urandom_range(0, 19) == 0);
            if (load) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    div_val[i*DIV_W +: DIV_W]   = DIV_W'($urandom_range(0, 9));
                    phase_val[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 12));
                end
            end
            clr_lost = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 29) == 0) ch_en = NUM_CH'($urandom);
            tick();
        end

        reset    = 1'b0;
        load     = 1'b0;
        clr_lost = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
